// File: rtl/gerador_coord_destino.sv
// Raster scanner for the reduced destination image. It emits one (x, y) coordinate per
// valid/ready transfer, in row-major order, and is controlled through start/busy/done hooks.
module gerador_coord_destino #(
  parameter int LARG_FONTE = 640,
  parameter int ALT_FONTE  = 480,
  parameter int W          = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         iniciar,
  input  logic [1:0]   fator_zoom,
  input  logic         pronto,
  output logic [W-1:0] x_destino,
  output logic [W-1:0] y_destino,
  output logic         valido,
  output logic         ultimo,
  output logic         ocupado,
  output logic         concluido
);

  typedef enum logic [1:0] {
    OCIOSO,
    VARRENDO,
    FIM
  } estado_t;

  localparam logic [W-1:0] LARG_W = W'(LARG_FONTE);
  localparam logic [W-1:0] ALT_W  = W'(ALT_FONTE);
  localparam logic [W-1:0] UM     = W'(1);

  estado_t      estado, estado_n;
  logic [W-1:0] larg_dest, larg_dest_n;
  logic [W-1:0] alt_dest, alt_dest_n;
  logic [W-1:0] x_n, y_n;
  logic         valido_n, ultimo_n, ocupado_n, concluido_n;

  logic [1:0]   shift;
  logic [W-1:0] larg_ini, alt_ini;
  logic [W-1:0] x_max, y_max;
  logic         transfer;

  // The destination size is computed once, when the frame starts, and is then held
  // so that changes to fator_zoom during a frame have no effect.
  assign shift    = (fator_zoom == 2'b11) ? 2'b00 : fator_zoom;
  assign larg_ini = LARG_W >> shift;
  assign alt_ini  = ALT_W >> shift;
  assign x_max    = larg_dest - UM;
  assign y_max    = alt_dest - UM;
  assign transfer = valido && pronto;

  always_comb begin
    estado_n    = estado;
    larg_dest_n = larg_dest;
    alt_dest_n  = alt_dest;
    x_n         = x_destino;
    y_n         = y_destino;
    valido_n    = valido;
    ultimo_n    = ultimo;
    ocupado_n   = ocupado;
    concluido_n = 1'b0;

    case (estado)
      OCIOSO: begin
        valido_n  = 1'b0;
        ultimo_n  = 1'b0;
        ocupado_n = 1'b0;
        if (iniciar) begin
          larg_dest_n = larg_ini;
          alt_dest_n  = alt_ini;
          x_n         = '0;
          y_n         = '0;
          valido_n    = 1'b1;
          ultimo_n    = (larg_ini == UM) && (alt_ini == UM);
          ocupado_n   = 1'b1;
          estado_n    = VARRENDO;
        end
      end

      VARRENDO: begin
        if (transfer) begin
          if (ultimo) begin
            valido_n    = 1'b0;
            ultimo_n    = 1'b0;
            concluido_n = 1'b1;
            estado_n    = FIM;
          end else begin
            if (x_destino != x_max) begin
              x_n = x_destino + UM;
            end else begin
              x_n = '0;
              y_n = y_destino + UM;
            end
            ultimo_n = (x_n == x_max) && (y_n == y_max);
          end
        end
      end

      FIM: begin
        ocupado_n = 1'b0;
        estado_n  = OCIOSO;
      end

      default: begin
        valido_n  = 1'b0;
        ultimo_n  = 1'b0;
        ocupado_n = 1'b0;
        estado_n  = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      estado    <= OCIOSO;
      larg_dest <= LARG_W;
      alt_dest  <= ALT_W;
      x_destino <= '0;
      y_destino <= '0;
      valido    <= 1'b0;
      ultimo    <= 1'b0;
      ocupado   <= 1'b0;
      concluido <= 1'b0;
    end else begin
      estado    <= estado_n;
      larg_dest <= larg_dest_n;
      alt_dest  <= alt_dest_n;
      x_destino <= x_n;
      y_destino <= y_n;
      valido    <= valido_n;
      ultimo    <= ultimo_n;
      ocupado   <= ocupado_n;
      concluido <= concluido_n;
    end
  end

endmodule
